// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module  : mem_access_pkg
// Brief   : Size encodings, FSM states and lane helpers for mem_access_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Replace the addressed lane of a memory word with right-aligned store data.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] merged;
        merged = word;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
        return merged;
    endfunction

    function automatic logic [31:0] load_extend(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: result = {{24{sgn & b[7]}}, b};
            SZ_HALF: result = {{16{sgn & h[15]}}, h};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module  : mem_lane_align
// Brief   : Combinational load lane select/extend and store lane merge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    assign load_data   = load_extend(mem_word, size, sgn, lane);
    assign merged_word = lane_merge(mem_word, store_data, size, lane);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Brief   : Load/store initiator for a word-addressed data memory; sub-word
//           stores are done as read-modify-write.
// Config  : MEM_ACCESS_ALIGN_CHECK_EN enables misalign/range error responses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e             state_q, state_d;
    logic               write_q, write_d;
    logic [1:0]         size_q, size_d;
    logic               signed_q, signed_d;
    logic [1:0]         lane_q, lane_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic               acc_err;
    logic [1:0]         req_size_norm;
    logic [31:0]        load_data;
    logic [31:0]        merged_word;

    assign req_size_norm = (req_size == 2'd3) ? SZ_WORD : req_size;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign acc_err = ((req_size_norm == SZ_HALF) && req_addr[0])
                   || ((req_size_norm == SZ_WORD) && (req_addr[1:0] != 2'b00))
                   || (req_addr >= ADDR_W'(MEM_BYTES));
`else
    assign acc_err = 1'b0;
`endif

    // Only the low half of store data can ever be merged into a lane.
    mem_lane_align u_lane_align (
        .size        (size_q),
        .sgn         (signed_q),
        .lane        (lane_q),
        .mem_word    (mem_rdata),
        .store_data  ({16'h0000, wdata_q}),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size_norm;
                    signed_d = req_signed;
                    lane_d   = req_addr[1:0];
                    wdata_d  = req_wdata[15:0];
                    if (acc_err) begin
                        state_d      = ST_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (!req_write || (req_size_norm != SZ_WORD)) begin
                        state_d    = ST_RD;
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    end else begin
                        state_d     = ST_WR;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ST_RD: begin
                if (write_q) begin
                    state_d     = ST_WR;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merged_word;
                end else begin
                    state_d      = ST_RESP;
                    resp_rdata_d = load_data;
                    resp_err_d   = 1'b0;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_rdata_d = 32'h0;
                resp_err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface in the multi-cycle MIPS datapath: accepts one load/store request from control and drives mem_read/mem_write/address/write_data to the word-addressed data memory.
- Memory read is combinational; memory write commits on posedge clk.
- Supports byte, half and word accesses, with sign or zero extension on loads.
- Sub-word stores use a read-modify-write sequence because the memory stores whole words only.

Parameters:
ADDR_W, 32, byte-address width on both the request and memory side.
MEM_BYTES, 4096, size of the memory; addresses >= MEM_BYTES are out of range (range check only under the optional feature).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle, request accepted when req_valid&&req_ready
req_write  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
req_signed  in  1  load sign-extend (lb/lh) vs zero-extend (lbu/lhu)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle pulse, request complete
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid; misaligned or out of range
mem_read  out  1  to memory read enable
mem_write  out  1  to memory write enable
mem_addr  out  ADDR_W  word-aligned address (low 2 bits are always 0)
mem_wdata  out  32  full word to write
mem_rdata  in  32  combinational read data

Behaviour:
- Reset: state=IDLE.
  - req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Reset mid-operation abandons the access with no memory write and no response.
- States: IDLE, RD, WR, RESP.
- On accept in IDLE, register write, size, signed, addr and wdata, then go to:
  - load -> RD
  - store word -> WR
  - store byte/half -> RD
  - error (optional feature only) -> RESP with err=1
- RD (1 cycle):
  - mem_read=1 and mem_addr={addr[ADDR_W-1:2],2'b00}; capture mem_rdata.
  - Load -> RESP.
  - Store -> WR, with merged word = captured word with the addressed byte or half lane replaced by wdata[7:0] or wdata[15:0].
  - Byte lane = addr[1:0]; half lane = addr[1].
- WR (1 cycle):
  - mem_write=1, mem_wdata = merged word (sub-word) or wdata (word); memory commits at the end of this cycle.
  - Next state RESP.
- RESP (1 cycle): resp_valid=1, then return to IDLE.
- Latency from the accept cycle: load 2 cycles; word store 2; sub-word store 3; error 1.
- req_ready=1 only in IDLE. No request overlap, so the next accept is possible the cycle after RESP.
- Load extension: select lane; sign-extend from bit 7/15 if req_signed, else zero-extend. Word loads pass through unchanged.
- mem_read and mem_write are never both 1. Both are 0 in IDLE and RESP.
- resp_rdata, resp_err and the mem_* outputs are registered. They hold their last value except that mem_read/mem_write return to 0.
- req_size=3 is treated as word with no error.

Optional Feature:
MEM_ACCESS_ALIGN_CHECK_EN
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, returns resp_err=1 and resp_rdata=0 with no memory cycles.
  - addr >= MEM_BYTES gives the same error.
- Undefined:
  - Low address bits below the access size are ignored: half uses addr[1] only, word forces addr[1:0]=0.
  - Out-of-range addresses are passed through unchanged; memory wraps on its own index bits.
  - resp_err is tied to 0.

Decomposition:
- Package mem_access_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, lane-merge and load-extend functions.
- One sub-module, mem_lane_align: combinational lane select/extend for loads and lane merge for stores. Shared by the FSM and the bench reference model.

Test Plan:
- Word store then load: sw 0x12345678 @0x10, then lw @0x10 -> exactly one mem_write cycle; load returns 0x12345678, latency 2.
- Byte merge: memory word @0x20=0xAABBCCDD; sb 0x11 @0x22 -> RD then WR with mem_wdata=0xAA11CCDD; lbu @0x22 -> 0x00000011.
- Sign extension: memory @0x30=0x0000F080; lb @0x30 -> 0xFFFFFF80; lh @0x30 -> 0xFFFFF080; lhu @0x30 -> 0x0000F080.
- Misalign with MEM_ACCESS_ALIGN_CHECK_EN: lw @0x13 -> resp_err=1 one cycle after accept, no mem_read/mem_write. Without the macro: lw @0x13 reads word @0x10, resp_err=0.
- Reset during a sub-word store: assert reset in RD -> no mem_write ever, req_ready=1 the cycle after reset, memory word unchanged.
- Back-to-back: req_valid held high for 3 requests -> each accepted only in IDLE; req_ready is 0 while busy; responses arrive in order.
